// File: rtl/text_window_renderer.sv
// text_window_renderer
//   COLS x ROWS character buffer fed by a valid/ready character stream, shown
//   inside a bordered window on the 640x480 raster. The buffer supports a
//   cursor, CR, backspace, line wrap and hardware scroll (row offset). The
//   3-stage pixel pipeline covers the buffer read and glyph ROM latencies.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   p_tick              pixel-enable strobe (used only for frame counting)
//   video_on, x, y      raster position from the VGA sync block
//   char_valid/char_code/char_ready   character stream (code[7] = Thai bank)
//   cursor_col, cursor_row            cursor position (screen coordinates)
//   rgb                 registered 12-bit pixel colour, 3 clk after x/y

module text_window_renderer #(
  parameter int COLS         = 32,
  parameter int ROWS         = 4,
  parameter int X0           = 192,
  parameter int Y0           = 208,
  parameter int BORDER       = 8,
  parameter int BLINK_FRAMES = 30,
  localparam int CW          = $clog2(COLS),
  localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          char_valid,
  input  logic [7:0]    char_code,
  output logic          char_ready,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic [11:0]   rgb
);

  localparam int AW = CW + RW;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BLNK = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCROLL} state_t;

  function automatic logic [RW-1:0] inc_row(input logic [RW-1:0] r);
    return (r == LAST_ROW) ? '0 : r + 1'b1;
  endfunction

  function automatic logic [11:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    return 12'hF00;
      3'd1:    return 12'hF81;
      3'd2:    return 12'hFF1;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'h00F;
      3'd5:    return 12'h408;
      3'd6:    return 12'hF0F;
      default: return 12'hF08;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM and cursor
  // ---------------------------------------------------------------------
  state_t          state, state_nx;
  logic [AW-1:0]   clr_cnt, clr_cnt_nx;
  logic [RW-1:0]   clr_row, clr_row_nx;
  logic [RW-1:0]   row_off, row_off_nx;
  logic [CW-1:0]   cur_col_nx;
  logic [RW-1:0]   cur_row_nx;
  logic [RW-1:0]   wr_row;
  logic            newline;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  assign char_ready = (state == ST_IDLE);
  assign wr_row     = cursor_row + row_off;

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    clr_row_nx = clr_row;
    row_off_nx = row_off;
    cur_col_nx = cursor_col;
    cur_row_nx = cursor_row;
    newline    = 1'b0;
    we         = 1'b0;
    waddr      = clr_cnt;
    wdata      = 8'h20;
    case (state)
      ST_INIT: begin
        we = 1'b1;
        if (clr_cnt == LAST_CELL) begin
          state_nx   = ST_IDLE;
          clr_cnt_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      ST_SCROLL: begin
        we    = 1'b1;
        waddr = {clr_row, clr_cnt[CW-1:0]};
        if (clr_cnt[CW-1:0] == LAST_COL) begin
          state_nx   = ST_IDLE;
          clr_cnt_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      default: begin
        if (char_valid) begin
          if (char_code == 8'h0D) begin
            cur_col_nx = '0;
            newline    = 1'b1;
          end else if (char_code == 8'h08) begin
            if (cursor_col != '0) begin
              cur_col_nx = cursor_col - 1'b1;
              we         = 1'b1;
              waddr      = {wr_row, cursor_col - 1'b1};
            end
          end else begin
            we    = 1'b1;
            waddr = {wr_row, cursor_col};
            wdata = char_code;
            if (cursor_col == LAST_COL) begin
              cur_col_nx = '0;
              newline    = 1'b1;
            end else begin
              cur_col_nx = cursor_col + 1'b1;
            end
          end
          // Bottom-row newline: rotate the offset so the old top physical
          // row becomes the new bottom row, then blank it.
          if (newline) begin
            if (cursor_row != LAST_ROW) begin
              cur_row_nx = cursor_row + 1'b1;
            end else begin
              row_off_nx = inc_row(row_off);
              clr_row_nx = row_off;
              clr_cnt_nx = '0;
              state_nx   = ST_SCROLL;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      clr_cnt    <= '0;
      clr_row    <= '0;
      row_off    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      clr_row    <= clr_row_nx;
      row_off    <= row_off_nx;
      cursor_col <= cur_col_nx;
      cursor_row <= cur_row_nx;
    end
  end

  // ---------------------------------------------------------------------
  // Cursor blink
  // ---------------------------------------------------------------------
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          frame_tick;

  assign frame_tick = p_tick && (x == '0) && (y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == LAST_BLNK) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Character buffer: one write port, one registered read port
  // ---------------------------------------------------------------------
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 0: window decode and buffer read
  // ---------------------------------------------------------------------
  int          xi, yi;
  logic        win0, frame0, hit0;
  logic [CW-1:0] col0;
  logic [RW-1:0] srow0;
  logic [2:0]  pal0;

  always_comb begin
    xi     = 32'(x);
    yi     = 32'(y);
    win0   = (xi >= X0) && (xi < X0 + 8 * COLS) &&
             (yi >= Y0) && (yi < Y0 + 16 * ROWS);
    frame0 = (xi >= X0 - BORDER) && (xi < X0 + 8 * COLS + BORDER) &&
             (yi >= Y0 - BORDER) && (yi < Y0 + 16 * ROWS + BORDER);
    col0   = CW'((x - 10'(X0)) >> 3);
    srow0  = RW'((y - 10'(Y0)) >> 4);
    rd_addr = {srow0 + row_off, col0};
    // Y0 is a multiple of 16, so y[3:0] is the glyph row directly.
    hit0   = blink_on && (srow0 == cursor_row) && (col0 == cursor_col) &&
             (y[3:1] == 3'b111);
    pal0   = 3'(col0 >> (CW - 3));
  end

  // Stage 1 / stage 2 side-band registers
  logic       s1_von, s1_win, s1_frame, s1_hit;
  logic [2:0] s1_xlo, s1_pal;
  logic [3:0] s1_grow;
  logic       s2_von, s2_win, s2_frame, s2_hit, s2_bank;
  logic [2:0] s2_xlo, s2_pal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_von <= 1'b0; s1_win <= 1'b0; s1_frame <= 1'b0; s1_hit <= 1'b0;
      s1_xlo <= '0;   s1_pal <= '0;   s1_grow  <= '0;
      s2_von <= 1'b0; s2_win <= 1'b0; s2_frame <= 1'b0; s2_hit <= 1'b0;
      s2_bank <= 1'b0; s2_xlo <= '0;  s2_pal   <= '0;
    end else begin
      s1_von   <= video_on;
      s1_win   <= win0;
      s1_frame <= frame0;
      s1_hit   <= hit0;
      s1_xlo   <= x[2:0];
      s1_pal   <= pal0;
      s1_grow  <= y[3:0];
      s2_von   <= s1_von;
      s2_win   <= s1_win;
      s2_frame <= s1_frame;
      s2_hit   <= s1_hit;
      s2_bank  <= rd_data[7];
      s2_xlo   <= s1_xlo;
      s2_pal   <= s1_pal;
    end
  end

  // Stage 1: glyph ROM address from buffer data
  logic [10:0] rom_addr;
  logic [7:0]  ascii_data, thai_data;

  assign rom_addr = {rd_data[6:0], s1_grow};

  ascii_rom u_ascii_rom (.clk(clk), .addr(rom_addr), .data(ascii_data));
  thai_rom  u_thai_rom  (.clk(clk), .addr(rom_addr), .data(thai_data));

  // Stage 2: bank select, bit pick, colour priority
  logic [7:0]  glyph;
  logic        pix;
  logic [11:0] rgb_nx;

  always_comb begin
    glyph = s2_bank ? thai_data : ascii_data;
    pix   = glyph[3'd7 - s2_xlo] ^ s2_hit;
    if (!s2_von)                  rgb_nx = 12'h000;
    else if (s2_win && pix)       rgb_nx = palette(s2_pal);
    else if (s2_frame && !s2_win) rgb_nx = 12'h000;
    else                          rgb_nx = 12'hFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb <= '0;
    else        rgb <= rgb_nx;
  end

endmodule

// ascii_rom: compact 8x16 font, 1-cycle synchronous read.
//   addr = {code[6:0], row[3:0]}; data bit 7 is the leftmost pixel.
//   Space is blank, 'A' and 'B' are full glyphs, other codes show a box.
module ascii_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

  logic [7:0] rd;
  int         sh;

  always_comb begin
    sh = 8 * (15 - 32'(addr[3:0]));
    case (addr[10:4])
      7'h20:   rd = 8'h00;
      7'h41:   rd = 8'(GLYPH_A >> sh);
      7'h42:   rd = 8'(GLYPH_B >> sh);
      default: rd = (addr[3:0] >= 4'd2 && addr[3:0] <= 4'd13) ? 8'h7E : 8'h00;
    endcase
  end

  always_ff @(posedge clk) data <= rd;
endmodule

// thai_rom: compact Thai bank, 1-cycle synchronous read.
//   addr = {code[6:0], row[3:0]}; only code 0x21 (ko kai) is populated.
module thai_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  localparam logic [127:0] GLYPH_KO = 128'h0000_0000_7CC6_0666_D6C6_C6C6_0000_0000;

  logic [7:0] rd;
  int         sh;

  always_comb begin
    sh = 8 * (15 - 32'(addr[3:0]));
    if (addr[10:4] == 7'h21) rd = 8'(GLYPH_KO >> sh);
    else                     rd = 8'h00;
  end

  always_ff @(posedge clk) data <= rd;
endmodule

// File: tb/tb_text_window_renderer.sv
// Directed bench for text_window_renderer (default parameters:
// 32x4 window at (192,208), 8-pixel border, 30-frame blink).

module tb_text_window_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p_tick;
  logic       video_on;
  logic [9:0] x, y;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_ready;
  logic [4:0] cursor_col;
  logic [1:0] cursor_row;
  logic [11:0] rgb;

  int errors = 0;
  int checks = 0;

  // Hand-entered 8x16 rows for 'A' (ascii 0x41), 'B' and Thai 0x21.
  logic [7:0] a_rows  [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] ko_rows [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h66,
                               8'hD6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  text_window_renderer #(
    .COLS(32), .ROWS(4), .X0(192), .Y0(208), .BORDER(8), .BLINK_FRAMES(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .char_valid(char_valid), .char_code(char_code),
    .char_ready(char_ready), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .rgb(rgb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int px, input int py, input logic von, output logic [11:0] r);
    @(negedge clk);
    x = 10'(px); y = 10'(py); video_on = von;
    repeat (3) @(negedge clk);
    r = rgb;
  endtask

  task automatic chk_pix(input string tag, input int px, input int py, input logic [11:0] exp);
    logic [11:0] r;
    pix(px, py, 1'b1, r);
    chk(tag, r, exp);
  endtask

  task automatic send(input logic [7:0] code);
    int n;
    n = 0;
    @(negedge clk);
    char_valid = 1'b1; char_code = code;
    while (!char_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", char_ready, 1'b1);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    chk({tag, "_row"}, cursor_row, r);
    chk({tag, "_col"}, cursor_col, c);
  endtask

  initial begin
    int cyc;
    logic [11:0] r;

    rst_n = 1'b0; p_tick = 1'b0; video_on = 1'b1;
    x = 10'd200; y = 10'd210; char_valid = 1'b0; char_code = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_ready", char_ready, 1'b0);
    chk_cursor("rst", 0, 0);

    // INIT length
    rst_n = 1'b1;
    cyc = 0;
    while (!char_ready && cyc < 1000) begin
      @(posedge clk); #1;
      if (!char_ready) cyc++;
    end
    chk("init_cycles", cyc + 1, 128);
    chk("init_ready", char_ready, 1'b1);

    chk_pix("blank_win", 200, 210, 12'hFFF);

    // 'A' at (0,0)
    send(8'h41);
    chk_cursor("after_A", 0, 1);
    for (int gr = 0; gr < 16; gr++)
      for (int gc = 0; gc < 8; gc++)
        chk_pix($sformatf("A_r%0d_c%0d", gr, gc), 192 + gc, 208 + gr,
                a_rows[gr][7 - gc] ? 12'hF00 : 12'hFFF);

    // Exact 3-clock latency
    chk_pix("lat_pre", 100, 100, 12'hFFF);
    @(negedge clk);
    x = 10'd194; y = 10'd211;
    repeat (2) @(negedge clk);
    chk("lat_2clk", rgb, 12'hFFF);
    @(negedge clk);
    chk("lat_3clk", rgb, 12'hF00);

    // Thai bank at (0,1)
    send(8'hA1);
    chk_cursor("after_thai", 0, 2);
    for (int gc = 0; gc < 8; gc++) begin
      chk_pix($sformatf("ko_r4_c%0d", gc), 200 + gc, 212,
              ko_rows[4][7 - gc] ? 12'hF00 : 12'hFFF);
      chk_pix($sformatf("ko_r8_c%0d", gc), 200 + gc, 216,
              ko_rows[8][7 - gc] ? 12'hF00 : 12'hFFF);
    end

    // Cursor underline at (0,2) and blink timing
    chk_pix("cur_on_r14", 208, 222, 12'hF00);
    chk_pix("cur_on_r15", 211, 223, 12'hF00);
    chk_pix("cur_r13", 208, 221, 12'hFFF);
    @(negedge clk); x = '0; y = '0; p_tick = 1'b1;
    repeat (29) @(negedge clk);
    p_tick = 1'b0;
    chk_pix("blink_29", 208, 222, 12'hF00);
    @(negedge clk); x = '0; y = '0; p_tick = 1'b1;
    @(negedge clk); p_tick = 1'b0;
    chk_pix("blink_30", 208, 222, 12'hFFF);
    @(negedge clk); x = '0; y = '0; p_tick = 1'b1;
    repeat (30) @(negedge clk);
    p_tick = 1'b0;
    chk_pix("blink_60", 208, 222, 12'hF00);

    // CR, then B / BS / BS on row 1
    send(8'h0D);
    chk_cursor("after_cr", 1, 0);
    send(8'h42);
    chk_cursor("after_B", 1, 1);
    chk_pix("B_shown", 192, 226, 12'hF00);
    send(8'h08);
    chk_cursor("bs1", 1, 0);
    chk_pix("B_cleared", 192, 226, 12'hFFF);
    send(8'h08);
    chk_cursor("bs_col0", 1, 0);

    // Wrap across rows 1..3
    for (int i = 0; i < 31; i++) send(8'h41);
    chk_cursor("row1_col31", 1, 31);
    send(8'h41);
    chk_cursor("wrap1", 2, 0);
    for (int i = 0; i < 32; i++) send(8'h41);
    chk_cursor("wrap2", 3, 0);
    for (int i = 0; i < 31; i++) send(8'h41);
    chk_cursor("row3_col31", 3, 31);

    // Final character on the bottom row triggers the scroll
    @(negedge clk);
    char_valid = 1'b1; char_code = 8'h41;
    chk("pre_scroll_ready", char_ready, 1'b1);
    @(posedge clk); #1;
    char_valid = 1'b0;
    cyc = 0;
    while (!char_ready && cyc < 1000) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("scroll_cycles", cyc, 32);
    chk_cursor("after_scroll", 3, 0);

    // Screen row 0 is now the old row 1 (all 'A'); Thai glyph gone
    chk_pix("top_A_bit7", 192, 216, 12'hF00);
    chk_pix("top_col1_c3", 203, 216, 12'hFFF);
    chk_pix("row2_A", 200, 248, 12'hF00);
    chk_pix("bottom_clear", 200, 264, 12'hFFF);
    chk_pix("pal_col4", 224, 248, 12'hF81);
    chk_pix("pal_col31", 440, 248, 12'hF08);

    // Colour priority and border
    pix(200, 248, 1'b0, r);
    chk("video_off", r, 12'h000);
    chk_pix("border_left", 186, 250, 12'h000);
    chk_pix("border_right", 448, 230, 12'h000);
    chk_pix("border_corner", 455, 279, 12'h000);
    chk_pix("outside_corner", 456, 279, 12'hFFF);
    chk_pix("outside", 100, 100, 12'hFFF);

    // Reset mid-operation
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rerst_rgb", rgb, 12'h000);
    chk("rerst_ready", char_ready, 1'b0);
    chk_cursor("rerst", 0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rerst_init", char_ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
